// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
// ----------------
// Self-test wrapper for one 3-input truth-table gate. The checker steps the
// gate inputs through rows 000..111. Each row is held for SETTLE_CYCLES
// cycles, and then dut_out is sampled for SAMPLE_COUNT cycles. The value seen
// on the last sample of row i becomes bit (7-i) of the observed truth word.
// This bit order follows the hex naming of the gate modules, so row 000 maps
// to bit 7. Any change of dut_out inside a row's sample window sets that
// row's unstable flag. At the end of the sweep the observed word is compared
// with the expected word that was latched when the sweep started.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     sweep request, accepted only while idle
//   expected  expected truth word, latched on start acceptance
//   in1..in3  gate inputs; {in1,in2,in3} is the current row index
//   dut_out   gate output under test
//   busy      high during settle/sample cycles
//   done      one-cycle pulse when the sweep completes
//   tt        observed truth word
//   unstable  per-row flag: dut_out moved during that row's sample window
//   pass      tt matches the latched expected word and no row was unstable
module tt_sweep_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_COUNT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic [7:0] unstable,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_COUNT - 1);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic [3:0] sample_cnt_q, sample_cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] tt_q, tt_d;
    logic [7:0] unst_q, unst_d;
    logic       ref_q, ref_d;
    logic       pass_q, pass_d;
    logic [2:0] bit_idx;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= 3'd0;
            settle_cnt_q <= 8'd0;
            sample_cnt_q <= 4'd0;
            exp_q        <= 8'h00;
            tt_q         <= 8'h00;
            unst_q       <= 8'h00;
            ref_q        <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            exp_q        <= exp_d;
            tt_q         <= tt_d;
            unst_q       <= unst_d;
            ref_q        <= ref_d;
            pass_q       <= pass_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = SETTLE;
            SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE: begin
                if (sample_cnt_q == SAMPLE_LAST) begin
                    // Row 7 always leaves the sweep, so the row counter never wraps.
                    state_d = (row_q == 3'd7) ? FINISH : SETTLE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, row stepping and result capture.
    always_comb begin
        row_d        = row_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        exp_d        = exp_q;
        tt_d         = tt_q;
        unst_d       = unst_q;
        ref_d        = ref_q;
        pass_d       = pass_q;
        bit_idx      = 3'd7 - row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d  = expected;
                    tt_d   = 8'h00;
                    unst_d = 8'h00;
                    pass_d = 1'b0;
                    row_d  = 3'd0;
                end
            end
            SETTLE: begin
                settle_cnt_d = (settle_cnt_q == SETTLE_LAST) ? 8'd0 : settle_cnt_q + 8'd1;
            end
            SAMPLE: begin
                // The first sample is the reference for the rest of the window.
                if (sample_cnt_q == 4'd0) begin
                    ref_d = dut_out;
                end else if (dut_out != ref_q) begin
                    unst_d[bit_idx] = 1'b1;
                end
                if (sample_cnt_q == SAMPLE_LAST) begin
                    tt_d[bit_idx] = dut_out;
                    sample_cnt_d  = 4'd0;
                    if (row_q == 3'd7) begin
                        // Registered together with the final tt bit so that
                        // pass is already valid in the done cycle.
                        pass_d = (tt_d == exp_q) && (unst_d == 8'h00);
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                end
            end
            FINISH: row_d = 3'd0;
            default: row_d = 3'd0;
        endcase
    end

    // Outputs.
    always_comb begin
        busy     = (state_q == SETTLE) || (state_q == SAMPLE);
        done     = (state_q == FINISH);
        in1      = row_q[2];
        in2      = row_q[1];
        in3      = row_q[0];
        tt       = tt_q;
        unstable = unst_q;
        pass     = pass_q;
    end

endmodule
